// File: rtl/fpu_request_arbiter.sv
// Round-robin arbiter that shares one fixed-point unit between two requesters,
// holding the unit's inputs steady and buffering one response with a ready timeout.
module fpu_request_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic             prio_reg, prio_next;   // requester that wins the next tie
  logic [7:0]       count_reg, count_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             id_reg, id_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             err_reg, err_next;
  logic             grant_id;
  logic [1:0]       grant_onehot;

  assign grant_id     = (req_valid == 2'b11) ? prio_reg : req_valid[1];
  assign grant_onehot = grant_id ? 2'b10 : 2'b01;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      prio_reg  <= 1'b0;
      count_reg <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      id_reg    <= 1'b0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      id_reg    <= id_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    count_next = count_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    id_next    = id_reg;
    data_next  = data_reg;
    err_next   = err_reg;
    req_ready  = 2'b00;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          // reset gating keeps req_ready low while the block is held in reset
          req_ready  = reset ? 2'b00 : grant_onehot;
          op_next    = grant_id ? req1_op : req0_op;
          a_next     = grant_id ? req1_a : req0_a;
          b_next     = grant_id ? req1_b : req0_b;
          id_next    = grant_id;
          prio_next  = ~grant_id;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // fpu_ready here belongs to the previous operation and is ignored
        count_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (fpu_ready) begin
          data_next  = fpu_result;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (count_reg == 8'(TIMEOUT - 1)) begin
          data_next  = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_valid    = (state_reg == RESP);
  assign resp_id       = id_reg;
  assign resp_data     = data_reg;
  assign resp_err      = err_reg;
  assign fpu_operation = op_reg;
  assign fpu_operand_1 = a_reg;
  assign fpu_operand_2 = b_reg;

endmodule

// File: doc/fpu_request_arbiter.md
FPU_REQUEST_ARBITER -- requirements
Module: fpu_request_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles to wait for fpu_ready (range 2..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 req_ready  output  2  per-requester request accepted this cycle (one-hot or zero).
REQ-007 req0_op, req1_op  input  2 each  FPU operation code (shared FPU_ADD/SUB/MUL/SQRT encoding).
REQ-008 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-009 fpu_operand_1, fpu_operand_2  output  WIDTH each  operands to the fixed-point unit.
REQ-010 fpu_operation  output  2  operation to the fixed-point unit.
REQ-011 fpu_result  input  WIDTH  fixed-point unit result.
REQ-012 fpu_ready  input  1  fixed-point unit result-valid.
REQ-013 resp_valid  output  1  response available.
REQ-014 resp_ready  input  1  response consumer ready.
REQ-015 resp_id  output  1  requester index the response belongs to.
REQ-016 resp_data  output  WIDTH  captured result.
REQ-017 resp_err  output  1  response is a timeout abort; resp_data = 0.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; every transition on a rising clk edge.
REQ-019 IDLE: with any req_valid set, the arbiter SHALL grant one requester, assert that req_ready bit combinationally in the same cycle, latch its op/operands, and go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-021 A lone valid requester SHALL be granted regardless of round-robin priority.
REQ-022 req_ready SHALL be 0 in every state except IDLE.
REQ-023 fpu_operation, fpu_operand_1, fpu_operand_2 SHALL be driven from the latched registers and held constant from ISSUE until leaving WAIT; the unit's multi-cycle MUL/SQRT sequencing restarts if operation changes.
REQ-024 ISSUE SHALL last exactly one cycle, ignore fpu_ready (stale result guard), clear the timeout counter, and go to WAIT.
REQ-025 WAIT: on fpu_ready=1, the block SHALL capture fpu_result into resp_data, set resp_err=0, and go to RESP.
REQ-026 WAIT: the timeout counter SHALL increment each cycle without fpu_ready; on reaching TIMEOUT, go to RESP with resp_err=1 and resp_data=0.
REQ-027 If fpu_ready rises in the same cycle the counter reaches TIMEOUT, the block SHALL treat it as success.
REQ-028 RESP: resp_valid SHALL be 1; resp_id/resp_data/resp_err SHALL be stable until handshake (resp_valid & resp_ready), then go to IDLE.
REQ-029 New requests SHALL NOT be granted in the handshake cycle; the earliest next grant is the following cycle.
REQ-030 Latency: ADD/SUB (fpu_ready high next cycle) SHALL yield resp_valid 3 cycles after the grant cycle.
REQ-031 Outside ISSUE/WAIT, fpu_operation/operands SHALL keep their last latched values (no glitching to the unit).
REQ-032 Deasserting req_valid after grant SHALL NOT affect the in-flight operation.

Reset
REQ-033 On reset, the block SHALL go to IDLE immediately and asynchronously.
REQ-034 Reset values SHALL be: req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, fpu_operation=0, fpu_operand_1=0, fpu_operand_2=0, timeout counter=0, round-robin pointer=requester 0.
REQ-035 Reset mid-WAIT or mid-RESP SHALL discard the transaction with no response issued.

Verification
REQ-036 Single ADD: req0 valid, op=FPU_ADD, a=0x00000C00, b=0x00000400; model returns sum with fpu_ready next cycle -> req_ready[0] in cycle 0, resp_valid in cycle 3, resp_id=0, resp_data=0x00001000, resp_err=0.
REQ-037 Tie fairness: both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 over 4 transactions and resp_id sequence matches.
REQ-038 Long MUL: model holds fpu_ready low for 6 cycles -> fpu_operation stays FPU_MUL and operands stay constant throughout; resp_data equals the model result.
REQ-039 Timeout: fpu_ready never asserted, TIMEOUT=64 -> resp_valid with resp_err=1 and resp_data=0 exactly 64 cycles after entering WAIT.
REQ-040 Backpressure: resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready stays 0, and no new grant until one cycle after the handshake.
REQ-041 Reset in WAIT: assert reset asynchronously mid-operation -> all outputs take reset values immediately, and no resp_valid follows after reset release.
